// File: rtl/ml_search_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : ml_search_scheduler_if
// Brief   : Start/status, metric-engine handshake and decision bus of the
//           ML search scheduler.
// Rev     : 1.0
// ============================================================================
interface ml_search_scheduler_if #(
   parameter int MW = 32
);
   logic          start;
   logic          busy;
   logic          cand_req;
   logic [4:0]    cand_q;
   logic          cand_ack;
   logic          met_valid;
   logic [MW-1:0] met_value;
   logic [2:0]    met_Imin_1;
   logic [2:0]    met_Qmin_1;
   logic [2:0]    met_Imin_2;
   logic [2:0]    met_Qmin_2;
   logic          dec_valid;
   logic [4:0]    q_min;
   logic [2:0]    m_Imin_1;
   logic [2:0]    m_Qmin_1;
   logic [2:0]    m_Imin_2;
   logic [2:0]    m_Qmin_2;
   logic [MW-1:0] min_metric;
   logic          err;

   // The scheduler itself
   modport slave (
      input  start, cand_ack, met_valid, met_value,
             met_Imin_1, met_Qmin_1, met_Imin_2, met_Qmin_2,
      output busy, cand_req, cand_q, dec_valid, q_min,
             m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2, min_metric, err
   );

   // Controller / metric engine / mapping stage side
   modport master (
      output start, cand_ack, met_valid, met_value,
             met_Imin_1, met_Qmin_1, met_Imin_2, met_Qmin_2,
      input  busy, cand_req, cand_q, dec_valid, q_min,
             m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2, min_metric, err
   );
endinterface
`default_nettype wire

// File: rtl/ml_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ml_search_scheduler
// Brief   : Walks all NUM_Q candidate matrices through the metric engine and
//           emits the minimum-metric candidate as a one-cycle decision.
// Rev     : 1.0
// ============================================================================
module ml_search_scheduler #(
   parameter int NUM_Q = 16,
   parameter int MW    = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   ml_search_scheduler_if.slave  bus
);

   localparam logic [4:0] c_Q_LAST = 5'(NUM_Q - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [4:0]    r_q;
   logic [4:0]    w_q_nxt;
   logic          r_err;
   logic          w_err_nxt;
   logic          w_load_best;

   logic          r_busy;
   logic          r_cand_req;
   logic          r_dec_valid;

   logic [MW-1:0] r_min_metric;
   logic [4:0]    r_q_min;
   logic [2:0]    r_m_imin_1;
   logic [2:0]    r_m_qmin_1;
   logic [2:0]    r_m_imin_2;
   logic [2:0]    r_m_qmin_2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_err_nxt   = r_err;
      w_load_best = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_ISSUE;
               w_q_nxt     = 5'd0;
               w_err_nxt   = 1'b0;
            end
         end
         S_ISSUE: begin
            if (bus.cand_ack) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.met_valid) begin
               // Strict compare: an equal metric never displaces an earlier candidate
               w_load_best = (r_q == 5'd0) || (bus.met_value < r_min_metric);
               if (r_q == c_Q_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_q_nxt     = r_q + 5'd1;
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Protocol violations win over the clear done by an accepted start
      if (bus.met_valid && (r_state != S_WAIT)) begin
         w_err_nxt = 1'b1;
      end
      if (bus.start && (r_state != S_IDLE)) begin
         w_err_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q          <= 5'd0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
         r_cand_req   <= 1'b0;
         r_dec_valid  <= 1'b0;
         r_min_metric <= '0;
         r_q_min      <= 5'd0;
         r_m_imin_1   <= 3'd0;
         r_m_qmin_1   <= 3'd0;
         r_m_imin_2   <= 3'd0;
         r_m_qmin_2   <= 3'd0;
      end else begin
         r_q         <= w_q_nxt;
         r_err       <= w_err_nxt;
         // Status strobes are decoded from the next state so they align with it
         r_busy      <= (w_state_nxt != S_IDLE);
         r_cand_req  <= (w_state_nxt == S_ISSUE);
         r_dec_valid <= (w_state_nxt == S_DONE);
         if (w_load_best) begin
            r_min_metric <= bus.met_value;
            r_q_min      <= r_q;
            r_m_imin_1   <= bus.met_Imin_1;
            r_m_qmin_1   <= bus.met_Qmin_1;
            r_m_imin_2   <= bus.met_Imin_2;
            r_m_qmin_2   <= bus.met_Qmin_2;
         end
      end
   end

   assign bus.busy       = r_busy;
   assign bus.cand_req   = r_cand_req;
   assign bus.cand_q     = r_q;
   assign bus.dec_valid  = r_dec_valid;
   assign bus.err        = r_err;
   assign bus.min_metric = r_min_metric;
   assign bus.q_min      = r_q_min;
   assign bus.m_Imin_1   = r_m_imin_1;
   assign bus.m_Qmin_1   = r_m_qmin_1;
   assign bus.m_Imin_2   = r_m_imin_2;
   assign bus.m_Qmin_2   = r_m_qmin_2;

endmodule
`default_nettype wire

// File: tb/tb_ml_search_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_ml_search_scheduler
// Brief   : Self-checking bench: table-driven metric engine plus a timing and
//           arg-min model derived from the search rules.
// Rev     : 1.0
// ============================================================================
module tb_ml_search_scheduler;
   localparam int NUM_Q = 16;
   localparam int MW    = 32;
   localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ml_search_scheduler_if #(.MW(MW)) bus ();
   ml_search_scheduler #(.NUM_Q(NUM_Q), .MW(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic          tb_start = 1'b0, inj_mv = 1'b0;
   logic          eng_ack = 1'b0, eng_mv = 1'b0;
   logic [MW-1:0] eng_val = '0;
   logic [2:0]    eng_ind [4];

   assign bus.start      = tb_start;
   assign bus.cand_ack   = eng_ack;
   assign bus.met_valid  = eng_mv | inj_mv;
   assign bus.met_value  = eng_val;
   assign bus.met_Imin_1 = eng_ind[0];
   assign bus.met_Qmin_1 = eng_ind[1];
   assign bus.met_Imin_2 = eng_ind[2];
   assign bus.met_Qmin_2 = eng_ind[3];

   // Per-search stimulus tables
   logic [MW-1:0] met_tab [NUM_Q];
   logic [2:0]    ind_tab [NUM_Q][4];
   int            ad [NUM_Q];
   int            md [NUM_Q];

   int cyc = 0;
   int s_t = -100, s_abort = 32'h3fff_ffff, s_dec = -100;
   int last_dec_cyc = -1;
   int unsigned n_checks = 0, n_fail = 0;
   bit chk_on = 1'b0;

   logic          exp_err = 1'b0;
   int            eb_q = 0;
   logic [MW-1:0] eb_met = '0;
   logic [2:0]    eb_ind [4];

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Expected phase of cycle c from start cycle and per-candidate handshake delays
   function automatic void phase(input int c, output int ph, output int k);
      int off;
      ph = P_IDLE;
      k  = 0;
      if (c <= s_t || c >= s_abort) return;
      off = c - (s_t + 1);
      for (int j = 0; j < NUM_Q; j++) begin
         if (off < ad[j] + 1) begin ph = P_ISSUE; k = j; return; end
         off -= ad[j] + 1;
         if (off < md[j] + 1) begin ph = P_WAIT; k = j; return; end
         off -= md[j] + 1;
      end
      if (off == 0) ph = P_DONE;
   endfunction

   // Metric engine: acks after ad[q] stall cycles, answers after md[q] more
   bit pending = 1'b0;
   int ack_cnt = 0, met_cnt = 0, pq = 0;
   always @(posedge clk) begin
      #2;
      eng_ack = 1'b0;
      eng_mv  = 1'b0;
      eng_val = $urandom;
      for (int i = 0; i < 4; i++) eng_ind[i] = 3'($urandom);
      if (rst) begin
         pending = 1'b0;
         ack_cnt = 0;
         met_cnt = 0;
      end else if (pending) begin
         eng_ack = 1'($urandom);
         if (met_cnt == md[pq]) begin
            eng_mv  = 1'b1;
            eng_val = met_tab[pq];
            for (int i = 0; i < 4; i++) eng_ind[i] = ind_tab[pq][i];
            pending = 1'b0;
         end else begin
            met_cnt++;
         end
      end else if (bus.cand_req && int'(bus.cand_q) < NUM_Q) begin
         if (ack_cnt == ad[bus.cand_q]) begin
            eng_ack = 1'b1;
            pending = 1'b1;
            pq      = int'(bus.cand_q);
            met_cnt = 0;
            ack_cnt = 0;
         end else begin
            ack_cnt++;
         end
      end else begin
         eng_ack = 1'($urandom);
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      int ph, k;
      logic [MW-1:0] mn;
      if (chk_on) begin
         phase(cyc, ph, k);
         if (ph == P_DONE) begin
            mn = met_tab[0];
            for (int j = 1; j < NUM_Q; j++) if (met_tab[j] < mn) mn = met_tab[j];
            for (int j = NUM_Q - 1; j >= 0; j--) begin
               if (met_tab[j] == mn) begin
                  eb_q = j;
                  for (int i = 0; i < 4; i++) eb_ind[i] = ind_tab[j][i];
               end
            end
            eb_met = mn;
         end
         check("busy", 64'(bus.busy), 64'(ph != P_IDLE));
         check("cand_req", 64'(bus.cand_req), 64'(ph == P_ISSUE));
         if (ph == P_ISSUE) check("cand_q", 64'(bus.cand_q), 64'(k));
         check("dec_valid", 64'(bus.dec_valid), 64'(ph == P_DONE));
         check("err", 64'(bus.err), 64'(exp_err));
         if (ph == P_DONE || ph == P_IDLE) begin
            check("q_min", 64'(bus.q_min), 64'(eb_q));
            check("min_metric", 64'(bus.min_metric), 64'(eb_met));
            check("m_Imin_1", 64'(bus.m_Imin_1), 64'(eb_ind[0]));
            check("m_Qmin_1", 64'(bus.m_Qmin_1), 64'(eb_ind[1]));
            check("m_Imin_2", 64'(bus.m_Imin_2), 64'(eb_ind[2]));
            check("m_Qmin_2", 64'(bus.m_Qmin_2), 64'(eb_ind[3]));
         end
         if (bus.dec_valid) last_dec_cyc = cyc;
         if (rst) begin
            exp_err = 1'b0;
            eb_q    = 0;
            eb_met  = '0;
            for (int i = 0; i < 4; i++) eb_ind[i] = 3'd0;
         end else begin
            if (ph == P_IDLE && bus.start) exp_err = 1'b0;
            if (bus.met_valid && ph != P_WAIT) exp_err = 1'b1;
            if (bus.start && ph != P_IDLE) exp_err = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tables(input int kind);
      for (int j = 0; j < NUM_Q; j++) begin
         ad[j] = 0;
         md[j] = 0;
         for (int i = 0; i < 4; i++) ind_tab[j][i] = 3'($urandom_range(1, 4));
         case (kind)
            0:       met_tab[j] = (j == 5) ? MW'(3) : MW'(100 - j);
            1:       met_tab[j] = (j == 2 || j == 9) ? MW'(7) : MW'(50);
            default: begin
               met_tab[j] = MW'($urandom_range(0, 15));
               ad[j]      = $urandom_range(0, 2);
               md[j]      = $urandom_range(0, 2);
            end
         endcase
      end
   endtask

   task automatic start_search();
      int sum;
      sum = 0;
      for (int j = 0; j < NUM_Q; j++) sum += ad[j] + md[j];
      s_t      = cyc;
      s_abort  = 32'h3fff_ffff;
      s_dec    = s_t + 1 + 2 * NUM_Q + sum;
      tb_start = 1'b1;
      step();
      tb_start = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc <= s_dec) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int ph, k, r_cyc, first_dec, t0;
      bit found;
      for (int i = 0; i < 4; i++) begin eng_ind[i] = 3'd0; eb_ind[i] = 3'd0; end
      set_tables(0);
      rst = 1'b1;
      repeat (3) step();
      rst    = 1'b0;
      chk_on = 1'b1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_q_min", 64'(bus.q_min), 64'd0);
      check("rst_min_metric", 64'(bus.min_metric), 64'd0);
      step();

      // Immediate handshakes, metric 100-q with q=5 -> 3
      set_tables(0);
      start_search();
      t0 = s_t;
      wait_done();
      check("t1_latency", 64'(last_dec_cyc - t0), 64'd33);
      check("t1_q_min", 64'(bus.q_min), 64'd5);
      check("t1_min_metric", 64'(bus.min_metric), 64'd3);
      check("t1_m_Imin_1", 64'(bus.m_Imin_1), 64'(ind_tab[5][0]));
      check("t1_m_Qmin_2", 64'(bus.m_Qmin_2), 64'(ind_tab[5][3]));
      step();

      // Tie between q=2 and q=9
      set_tables(1);
      start_search();
      wait_done();
      check("tie_q_min", 64'(bus.q_min), 64'd2);
      check("tie_min_metric", 64'(bus.min_metric), 64'd7);
      step();

      // Stalls: ack late on q=0, metric late on q=1
      set_tables(0);
      ad[0] = 3;
      md[1] = 2;
      start_search();
      t0 = s_t;
      step();
      check("stall_cand_req", 64'(bus.cand_req), 64'd1);
      check("stall_cand_q", 64'(bus.cand_q), 64'd0);
      wait_done();
      check("stall_latency", 64'(last_dec_cyc - t0), 64'd38);
      step();

      // Protocol errors
      set_tables(0);
      inj_mv = 1'b1;
      step();
      inj_mv = 1'b0;
      check("perr_idle_mv", 64'(bus.err), 64'd1);
      start_search();
      repeat (3) step();
      tb_start = 1'b1;
      step();
      tb_start = 1'b0;
      step();
      check("perr_mid_start", 64'(bus.err), 64'd1);
      wait_done();
      check("perr_err_sticky", 64'(bus.err), 64'd1);
      check("perr_q_min", 64'(bus.q_min), 64'd5);
      set_tables(1);
      start_search();
      step();
      check("perr_cleared", 64'(bus.err), 64'd0);
      wait_done();
      step();

      // Reset during WAIT of q=7
      set_tables(0);
      start_search();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         phase(cyc, ph, k);
         if (ph == P_WAIT && k == 7) found = 1'b1;
         else step();
      end
      check("rst_reach_wait7", 64'(found), 64'd1);
      rst     = 1'b1;
      r_cyc   = cyc;
      s_abort = cyc + 1;
      step();
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_cand_req", 64'(bus.cand_req), 64'd0);
      check("abort_cand_q", 64'(bus.cand_q), 64'd0);
      check("abort_q_min", 64'(bus.q_min), 64'd0);
      check("abort_min_metric", 64'(bus.min_metric), 64'd0);
      repeat (4) step();
      check("abort_no_dec", 64'(last_dec_cyc < r_cyc - 14), 64'd1);
      set_tables(1);
      start_search();
      wait_done();
      check("post_rst_q_min", 64'(bus.q_min), 64'd2);

      // Back-to-back: restart in the first IDLE cycle after DONE
      set_tables(0);
      start_search();
      wait_done();
      first_dec = last_dec_cyc;
      set_tables(1);
      start_search();
      wait_done();
      check("b2b_gap", 64'(last_dec_cyc - first_dec), 64'(2 * NUM_Q + 2));

      // Randomised searches with ties and handshake stalls
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 2)) step();
         set_tables(2);
         start_search();
         wait_done();
      end

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ml_search_scheduler.md
# ml_search_scheduler

Sequences the exhaustive maximum-likelihood search over the candidate S matrices for one received block. Issues candidate indices to the shared metric engine and tracks the minimum-metric candidate with its four per-symbol indices. Delivers the winning q_min and m_*min_* set as a one-cycle decision pulse that drives the in_valid/q_min/m_* inputs of the symbol-mapping stage.

## Interface
- NUM_Q, default 16: number of candidate matrices searched, legal range 2..32
- MW, default 32: metric width, unsigned
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a search; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- cand_req  out  1  candidate request to metric engine
- cand_q  out  5  candidate index; valid while cand_req high
- cand_ack  in  1  engine accepts request; transfer when cand_req & cand_ack
- met_valid  in  1  metric result valid, one cycle
- met_value  in  MW  metric of the outstanding candidate
- met_Imin_1, met_Qmin_1, met_Imin_2, met_Qmin_2  in  3 each  per-symbol best indices (1..4) for that candidate
- dec_valid  out  1  one-cycle decision strobe
- q_min  out  5  winning candidate index
- m_Imin_1, m_Qmin_1, m_Imin_2, m_Qmin_2  out  3 each  winning per-symbol indices
- min_metric  out  MW  winning metric
- err  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 -> ISSUE. q counter cleared to 0, err cleared, best-valid flag cleared. start=0 -> stay.
- ISSUE: cand_req=1, cand_q=q. cand_ack=1 -> WAIT. Otherwise hold; cand_q stays stable.
- WAIT: cand_req=0. met_valid=1 -> compare and update, then:
  - If q==NUM_Q-1 -> DONE.
  - Else q+1 and -> ISSUE.
- DONE: dec_valid=1 for exactly this cycle, then -> IDLE.
- Compare rule:
  - First candidate of a search (q=0) loads best registers unconditionally.
  - Later candidates replace best only when met_value < min_metric, unsigned strict.
  - Ties keep the lower q.
- Best registers: min_metric, q_min, and the four m outputs update together. They hold their values after DONE until the next search's q=0 result.
- Protocol errors set err=1 (sticky until next accepted start or rst); the offending input is otherwise ignored:
  - met_valid=1 in any state other than WAIT.
  - start=1 while busy.
- cand_ack outside ISSUE is ignored; no error.
- q counter is 5 bits. It never exceeds NUM_Q-1, so no wrap.

## Timing
- Reset values, applied at the first rising edge with rst=1:
  - State IDLE.
  - busy, cand_req, dec_valid, err = 0.
  - cand_q, q_min, the four m outputs, min_metric = 0.
- Reset mid-search aborts with no dec_valid. cand_req is low from the edge that samples rst.
- rst has priority over start, met_valid and cand_ack in the same cycle.
- All outputs are registered; there is no combinational input-to-output path.
- With start sampled at edge t, ack in the same cycle as req, and met_valid in the first WAIT cycle:
  - Candidate k: ISSUE in cycle t+1+2k, WAIT in cycle t+2+2k.
  - dec_valid in cycle t+1+2*NUM_Q (NUM_Q=16 -> t+33).
- Each cycle of cand_ack or met_valid delay adds exactly one cycle to the total latency.
- busy rises the cycle after start is sampled and falls the cycle after DONE.
- start may be asserted again in the first IDLE cycle after DONE (back-to-back searches, one idle cycle between them).

## Test plan
- Immediate handshakes, NUM_Q=16, metrics 100-q except q=5 -> 3:
  - dec_valid at t+33.
  - q_min=5, min_metric=3, m outputs equal those returned with q=5.
- Tie: q=2 and q=9 both metric 7, all others 50:
  - q_min=2, min_metric=7.
- Stall: cand_ack delayed 3 cycles on q=0 and met_valid delayed 2 cycles on q=1, all else immediate:
  - cand_q held at 0 during the stall.
  - dec_valid at t+38.
- Protocol errors: met_valid pulsed in IDLE, then start pulsed mid-search:
  - err=1 and stays 1.
  - Search completes unaffected.
  - The next accepted start clears err.
- Reset: rst asserted during WAIT of q=7:
  - Next cycle all outputs at reset values; no dec_valid.
  - A fresh start completes normally.
- Back-to-back: second start in the first IDLE cycle after DONE:
  - Second dec_valid exactly 2*NUM_Q+2 cycles after the first.
